// File: rtl/lock_pkg.sv
// lock_pkg: shared state encoding, limits and parity helper for the key loader
package lock_pkg;
  typedef enum logic [2:0] {IDLE, SHIFT, CHECK, DONE, ERR, LOCKOUT} state_e;
  localparam int KEY_W_MAX = 32;
  localparam int TRIES_MAX = 7;
  function automatic logic parity(input logic [KEY_W_MAX-1:0] v);
    return ^v;
  endfunction
endpackage

// File: rtl/key_serial_loader_if.sv
// key_serial_loader_if: serial key-store link plus the key/reset lines to the locked core
interface key_serial_loader_if #(parameter int KEY_W = 1);
  logic load_start;
  logic key_sdi;
  logic key_svalid;
  logic key_sready;
  logic [KEY_W-1:0] key_out;
  logic key_valid;
  logic core_rst;
  logic key_err;
  logic busy;
  modport master (
    output load_start, key_sdi, key_svalid,
    input  key_sready, key_out, key_valid, core_rst, key_err, busy
  );
  modport slave (
    input  load_start, key_sdi, key_svalid,
    output key_sready, key_out, key_valid, core_rst, key_err, busy
  );
endinterface

// File: rtl/key_shift_reg.sv
// key_shift_reg: MSB-first shadow register with transfer counter flagging when the key is complete
module key_shift_reg #(
  parameter int KEY_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             din_i,
  output logic [KEY_W-1:0] shadow_o,
  output logic             count_done_o
);
  localparam int CW = $clog2(KEY_W + 2);
  logic [KEY_W-1:0] shadow_q;
  logic [CW-1:0]    cnt_q;
  // shift key bits in until KEY_W have arrived; the counter also counts the parity transfer
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      shadow_q <= '0;
      cnt_q    <= '0;
    end else if (clr_i) begin
      shadow_q <= '0;
      cnt_q    <= '0;
    end else if (en_i) begin
      if (!count_done_o) shadow_q <= KEY_W'({shadow_q, din_i});
      cnt_q <= cnt_q + 1'b1;
    end
  assign shadow_o     = shadow_q;
  assign count_done_o = cnt_q == CW'(KEY_W);
endmodule

// File: rtl/key_serial_loader.sv
// key_serial_loader: loads a parity-protected key serially and releases the locked core only on success
module key_serial_loader
  import lock_pkg::*;
#(
  parameter int KEY_W     = 1,
  parameter int MAX_TRIES = 3
) (
  input logic                clk,
  input logic                rst,
  key_serial_loader_if.slave bus
);
  state_e           state_q;
  logic [2:0]       tries_q, tries_d;
  logic             par_q, busy_q, key_valid_q, core_rst_q, key_err_q;
  logic [KEY_W-1:0] key_out_q, shadow;
  logic             count_done, clr, en, bad;
  assign clr     = (state_q == IDLE || state_q == ERR) && bus.load_start;
  assign en      = state_q == SHIFT && bus.key_svalid;
  assign bad     = parity(KEY_W_MAX'(shadow)) ^ par_q;
  assign tries_d = tries_q + 3'd1;
  key_shift_reg #(.KEY_W(KEY_W)) u_sr (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (clr),
    .en_i         (en),
    .din_i        (bus.key_sdi),
    .shadow_o     (shadow),
    .count_done_o (count_done)
  );
  // load sequencing; core-facing outputs follow state one cycle later so the key settles before core_rst drops
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q     <= IDLE;
      tries_q     <= '0;
      par_q       <= 1'b0;
      busy_q      <= 1'b0;
      key_valid_q <= 1'b0;
      core_rst_q  <= 1'b1;
      key_err_q   <= 1'b0;
      key_out_q   <= '0;
    end else begin
      key_valid_q <= state_q == DONE;
      key_out_q   <= state_q == DONE ? shadow : '0;
      core_rst_q  <= !key_valid_q;
      key_err_q   <= (state_q == ERR || state_q == LOCKOUT) ? 1'b1 : state_q == DONE ? 1'b0 : key_err_q;
      case (state_q)
        IDLE, ERR: if (bus.load_start) begin
          state_q <= SHIFT;
          busy_q  <= 1'b1;
        end
        SHIFT: if (en && count_done) begin
          par_q   <= bus.key_sdi;
          state_q <= CHECK;
        end
        CHECK: begin
          busy_q <= 1'b0;
          if (!bad) state_q <= DONE;
          else begin
            tries_q <= tries_d;
            state_q <= tries_d == 3'(MAX_TRIES) ? LOCKOUT : ERR;
          end
        end
        default: ;
      endcase
    end
  assign bus.key_sready = state_q == SHIFT;
  assign bus.busy       = busy_q;
  assign bus.key_out    = key_out_q;
  assign bus.key_valid  = key_valid_q;
  assign bus.core_rst   = core_rst_q;
  assign bus.key_err    = key_err_q;
endmodule

// File: tb/tb_key_serial_loader.sv
// tb_key_serial_loader: randomized loads checked by a queue scoreboard against a parity/try-count model
module tb_key_serial_loader;
  localparam int KW = 4;
  localparam int MT = 3;
  typedef struct packed {logic v; logic e; logic [KW-1:0] k;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  key_serial_loader_if #(.KEY_W(KW)) bus();
  key_serial_loader #(.KEY_W(KW), .MAX_TRIES(MT)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  exp_t q[$];
  int total = 0;
  int passed = 0;
  int tries = 0;
  bit done = 0;
  bit locked = 0;
  logic [KW-1:0] held = '0;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", n, act, exp);
  endtask
  task automatic do_reset();
    @(negedge clk);
    bus.key_svalid = 0;
    bus.load_start = 0;
    rst = 1;
    #1;
    chk("async_core_rst", bus.core_rst, 1);
    chk("async_sready", bus.key_sready, 0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_key_out", bus.key_out, 0);
    chk("rst_key_valid", bus.key_valid, 0);
    chk("rst_key_err", bus.key_err, 0);
    chk("rst_busy", bus.busy, 0);
    rst = 0;
    tries = 0;
    done = 0;
    locked = 0;
    held = '0;
  endtask
  task automatic send(input logic [KW:0] b, input int n, input int gm);
    int i = KW;
    int g = 0;
    bit ph = 0;
    bit acc;
    while (i > KW - n && g < 100) begin
      @(negedge clk);
      g++;
      bus.key_svalid = gm == 0 ? 1'b1 : gm == 1 ? ph : 1'($urandom_range(0, 1));
      ph = !ph;
      bus.key_sdi = b[i];
      acc = bus.key_svalid && bus.key_sready;
      @(posedge clk);
      if (acc) i--;
    end
    if (g >= 100) chk("send_timeout", 1, 0);
  endtask
  task automatic wait_drain();
    int g = 0;
    while (q.size() != 0 && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("result_seen", q.size() == 0, 1);
    repeat (4) @(negedge clk);
  endtask
  task automatic attempt(input logic [KW-1:0] k, input logic p, input int gm);
    if (done || locked) begin
      @(negedge clk);
      bus.load_start = 1;
      bus.key_svalid = 1;
      bus.key_sdi = 1;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        bus.load_start = 0;
        chk("ignored_sready", bus.key_sready, 0);
        chk("ignored_key_out", bus.key_out, done ? 32'(held) : 32'd0);
      end
      bus.key_svalid = 0;
      chk("ignored_key_err", bus.key_err, 32'(locked));
      chk("ignored_core_rst", bus.core_rst, 32'(!done));
      return;
    end
    @(negedge clk);
    bus.load_start = 1;
    @(negedge clk);
    bus.load_start = 0;
    chk("sready_after_start", bus.key_sready, 1);
    send({k, p}, KW + 1, gm);
    if ((^k) == p) begin
      done = 1;
      held = k;
      q.push_back('{v: 1'b1, e: 1'b0, k: k});
    end else begin
      tries++;
      if (tries >= MT) locked = 1;
      q.push_back('{v: 1'b0, e: 1'b1, k: '0});
    end
    @(negedge clk);
    bus.key_svalid = 0;
    wait_drain();
  endtask
  initial begin
    exp_t e;
    bit prev = 0;
    forever begin
      @(negedge clk);
      if (prev && !bus.busy && !rst) begin
        if (q.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          e = q.pop_front();
          chk("valid_not_early", bus.key_valid, 0);
          chk("key_out_not_early", bus.key_out, 0);
          @(negedge clk);
          chk("key_valid", bus.key_valid, 32'(e.v));
          chk("key_err", bus.key_err, 32'(e.e));
          chk("key_out", bus.key_out, 32'(e.k));
          chk("core_rst_hold", bus.core_rst, 1);
          @(negedge clk);
          chk("core_rst_release", bus.core_rst, 32'(!e.v));
        end
      end
      prev = bus.busy && !rst;
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
  initial begin
    logic [KW-1:0] k;
    logic p;
    bus.load_start = 0;
    bus.key_sdi = 0;
    bus.key_svalid = 0;
    do_reset();
    attempt(4'b1011, 1'b0, 0);
    attempt(4'b1011, 1'b1, 0);
    attempt(4'b0110, 1'b0, 2);
    do_reset();
    attempt(4'b1011, 1'b1, 1);
    do_reset();
    attempt(4'b0001, 1'b0, 0);
    attempt(4'b0111, 1'b0, 2);
    @(negedge clk);
    bus.load_start = 1;
    @(negedge clk);
    bus.load_start = 0;
    send(5'b10111, 2, 0);
    do_reset();
    attempt(4'b1000, 1'b0, 0);
    attempt(4'b1110, 1'b0, 1);
    attempt(4'b1011, 1'b1, 0);
    do_reset();
    attempt(4'b1011, 1'b0, 0);
    attempt(4'b0101, 1'b1, 2);
    attempt(4'b1111, 1'b1, 0);
    attempt(4'b1011, 1'b1, 0);
    for (int r = 0; r < 6; r++) begin
      do_reset();
      for (int a = 0; a < 5; a++) begin
        k = KW'($urandom);
        p = (^k) ^ ($urandom_range(0, 2) != 0);
        attempt(k, p, int'($urandom_range(0, 2)));
      end
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
